// File: rtl/data_memory_responder.sv
// Responder end of the data-memory request/response interface: a word-organised RAM
// with byte/half/word access, sign/zero extension, error detection and fixed access latency.
module data_memory_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          LATENCY      = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_write_value,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_value,
    output logic        resp_error
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDRESS} + 33'(4 * DEPTH_WORDS);
    localparam logic [2:0]  WAIT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  count;
    logic [2:0]  next_count;
    logic        accept;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_index;
    logic [1:0]       lane;
    logic             misaligned;
    logic             out_of_range;
    logic             bad_size;
    logic             req_err;

    logic [31:0] read_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [31:0] result_value;

    logic [3:0]  write_mask;
    logic [31:0] write_data;

    logic [31:0] held_value;
    logic        held_error;

    // Address decode and error classification for the request currently presented.
    always_comb begin
        word_index   = IDX_W'((req_address - BASE_ADDRESS) >> 2);
        lane         = req_address[1:0];
        bad_size     = (req_size == 2'b11);
        misaligned   = ((req_size == SIZE_HALF) && req_address[0]) ||
                       ((req_size == SIZE_WORD) && (req_address[1:0] != 2'b00));
        out_of_range = ({1'b0, req_address} < {1'b0, BASE_ADDRESS}) ||
                       ({1'b0, req_address} >= LIMIT);
        req_err      = bad_size || misaligned || out_of_range;
    end

    // Load path: pick the addressed lane(s) out of the word and extend to 32 bits.
    always_comb begin
        read_word  = mem[word_index];
        sel_byte   = 8'(read_word >> {lane, 3'b000});
        sel_half   = 16'(read_word >> {lane[1], 4'b0000});
        load_value = 32'h0;
        case (req_size)
            SIZE_BYTE: load_value = req_unsigned ? {24'h0, sel_byte}
                                                 : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_value = req_unsigned ? {16'h0, sel_half}
                                                 : {{16{sel_half[15]}}, sel_half};
            SIZE_WORD: load_value = read_word;
            default:   load_value = 32'h0;
        endcase
        result_value = (req_err || req_write) ? 32'h0 : load_value;
    end

    // Store path: replicate the right-justified data so the mask alone selects lanes.
    always_comb begin
        write_mask = 4'b0000;
        write_data = req_write_value;
        case (req_size)
            SIZE_BYTE: begin
                write_mask = 4'b0001 << lane;
                write_data = {4{req_write_value[7:0]}};
            end
            SIZE_HALF: begin
                write_mask = 4'b0011 << lane;
                write_data = {2{req_write_value[15:0]}};
            end
            SIZE_WORD: begin
                write_mask = 4'b1111;
                write_data = req_write_value;
            end
            default: begin
                write_mask = 4'b0000;
                write_data = req_write_value;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // RAM is never cleared; a store commits on its acceptance edge regardless of later reset.
    always_ff @(posedge clock) begin
        if (reset_n && accept && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (write_mask[b]) begin
                    mem[word_index][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        next_count = count;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        next_state = ST_RESPOND;
                    end else begin
                        next_state = ST_WAIT;
                        next_count = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (count == 3'd0) begin
                    next_state = ST_RESPOND;
                end else begin
                    next_count = count - 3'd1;
                end
            end
            ST_RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_count = 3'd0;
            end
        endcase
    end

    // Result is captured at acceptance, then copied to the response outputs on entry
    // to RESPOND so they stay frozen however long the initiator stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            count           <= 3'd0;
            held_value      <= 32'h0;
            held_error      <= 1'b0;
            resp_read_value <= 32'h0;
            resp_error      <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (accept) begin
                held_value <= result_value;
                held_error <= req_err;
            end
            if ((next_state == ST_RESPOND) && (state != ST_RESPOND)) begin
                if (state == ST_IDLE) begin
                    resp_read_value <= result_value;
                    resp_error      <= req_err;
                end else begin
                    resp_read_value <= held_value;
                    resp_error      <= held_error;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a table of directed transactions
// plus hand-written back-pressure and mid-transaction reset sequences.
module tb_data_memory_responder;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_write_value;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_value;
    logic        resp_error;

    int n_compared   = 0;
    int n_mismatched = 0;

    data_memory_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDRESS(32'h0),
        .LATENCY     (LAT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_write_value(req_write_value),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_read_value(resp_read_value),
        .resp_error     (resp_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wval;
        logic [31:0] exp_val;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wval,
                                input logic [31:0] exp_val, input logic exp_err);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.size = size; v.uns = uns;
        v.wval = wval; v.exp_val = exp_val; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full transaction; lat counts cycles from the acceptance cycle to resp_valid.
    task automatic applyStimulus(input vec_t v, output logic [31:0] val, output logic err,
                                 output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        req_write       = v.wr;
        req_address     = v.addr;
        req_size        = v.size;
        req_unsigned    = v.uns;
        req_write_value = v.wval;
        req_valid       = 1'b1;
        @(posedge clock); #1;
        req_valid       = 1'b0;
        req_address     = $urandom;
        req_write_value = $urandom;
        req_size        = 2'($urandom);
        req_unsigned    = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        val = resp_read_value;
        err = resp_error;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] val;
        logic        err;
        int          lat;
        int          guard;
        logic [31:0] held;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = 32'h0;
        req_size = 2'b10; req_unsigned = 1'b0; req_write_value = 32'h0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_read_value", resp_read_value, 32'h0);
        checkOutput("reset resp_error", 32'(resp_error), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        vecs.push_back(mk("sw_deadbeef", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk("lw_deadbeef", 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("sw_zero",     1, 32'h10, 2'b10, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk("sb_80",       1, 32'h11, 2'b00, 0, 32'hFFFFFF80, 32'h0, 0));
        vecs.push_back(mk("lb_80",       0, 32'h11, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu_80",      0, 32'h11, 2'b00, 1, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk("lw_8000",     0, 32'h10, 2'b10, 0, 32'h0, 32'h00008000, 0));
        vecs.push_back(mk("lh_8000",     0, 32'h10, 2'b01, 0, 32'h0, 32'hFFFF8000, 0));
        vecs.push_back(mk("lhu_8000",    0, 32'h10, 2'b01, 1, 32'h0, 32'h00008000, 0));
        vecs.push_back(mk("sh_1234",     1, 32'h12, 2'b01, 0, 32'hABCD1234, 32'h0, 0));
        vecs.push_back(mk("lh_1234",     0, 32'h12, 2'b01, 0, 32'h0, 32'h00001234, 0));
        vecs.push_back(mk("lh_misalign", 0, 32'h13, 2'b01, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk("sw_misalign", 1, 32'h12, 2'b10, 0, 32'h55555555, 32'h0, 1));
        vecs.push_back(mk("sh_misalign", 1, 32'h11, 2'b01, 0, 32'h00007777, 32'h0, 1));
        vecs.push_back(mk("lw_unchanged",0, 32'h10, 2'b10, 0, 32'h0, 32'h12348000, 0));
        vecs.push_back(mk("lb_lane3",    0, 32'h13, 2'b00, 0, 32'h0, 32'h00000012, 0));
        vecs.push_back(mk("sw_last",     1, 32'hFFC, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0));
        vecs.push_back(mk("lw_last_uns", 0, 32'hFFC, 2'b10, 1, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk("lb_fe",       0, 32'hFFE, 2'b00, 0, 32'h0, 32'hFFFFFFFE, 0));
        vecs.push_back(mk("lhu_cafe",    0, 32'hFFE, 2'b01, 1, 32'h0, 32'h0000CAFE, 0));
        vecs.push_back(mk("lw_oor",      0, 32'h1000, 2'b10, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk("lw_oor_top",  0, 32'hFFFFFFFC, 2'b10, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk("size11",      0, 32'h20, 2'b11, 0, 32'h0, 32'h0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], val, err, lat);
            checkOutput({vecs[i].name, " value"}, val, vecs[i].exp_val);
            checkOutput({vecs[i].name, " error"}, 32'(err), 32'(vecs[i].exp_err));
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(LAT));
        end

        // Back-pressure: response held for 5 cycles with a second request waiting.
        req_write = 1'b0; req_address = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_address = 32'hFFC;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        held = resp_read_value;
        checkOutput("stall value", held, 32'h12348000);
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
            checkOutput("stall data stable", resp_read_value, 32'h12348000);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        checkOutput("after transfer resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("after transfer req_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        checkOutput("pending accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("pending value", resp_read_value, 32'hCAFEF00D);
        checkOutput("pending error", 32'(resp_error), 32'd0);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;

        // Reset during WAIT drops the response but keeps the committed store.
        req_write = 1'b1; req_address = 32'h40; req_size = 2'b10;
        req_write_value = 32'h11223344; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checkOutput("in wait resp_valid", 32'(resp_valid), 32'd0);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        checkOutput("mid reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid reset req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("no late response", 32'(resp_valid), 32'd0);
        applyStimulus(mk("lw_dropped_store", 0, 32'h40, 2'b10, 0, 32'h0, 32'h11223344, 0),
                      val, err, lat);
        checkOutput("lw_dropped_store value", val, 32'h11223344);
        checkOutput("lw_dropped_store error", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
